argmax_datapath: RTL
====================

Name: argmax_datapath

Overview:
- Datapath partner of the readout argmax controller. Sits between the combination-stage output buffer (node × class scores) and the final classification result.
- For each node row 0..NUM_OF_NODES-1, it latches the WEIGHT_COLS class scores on the controller's read strobe.
- On the write strobe, it stores the index of the maximum score into a per-node result register file.
- It owns the node counter `cnt` that the controller consumes for its termination test.

Parameters:
- WEIGHT_COLS, 3, number of class scores per node row.
- DOT_PROD_WIDTH, 16, width of one score, signed two's complement.
- NUM_OF_NODES, 6, number of node rows to classify.
- COUNTER_FEATURE_WIDTH, $clog2(NUM_OF_NODES), width of `cnt` and the row address.
- MAX_ADDRESS_WIDTH, $clog2(WEIGHT_COLS) (=2), width of one stored argmax index.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- read, input, 1, controller strobe: latch the current row.
- write, input, 1, controller strobe: commit the argmax of the latched row.
- done, input, 1, controller completion flag.
- row_data, input, WEIGHT_COLS*DOT_PROD_WIDTH, scores of row `row_addr`; element k occupies bits [k*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]; combinational from the upstream buffer.
- row_addr, output, COUNTER_FEATURE_WIDTH, row index presented to the upstream buffer; equals `cnt`.
- cnt, output, COUNTER_FEATURE_WIDTH, current node index, fed back to the controller.
- max_addi_answer, output, NUM_OF_NODES × MAX_ADDRESS_WIDTH (unpacked array), argmax result per node.
- result_valid, output, 1, results complete and stable.

Behaviour:
- Reset (asynchronous, any time including mid-operation) clears:
  - `cnt`, `row_reg` and every `max_addi_answer` entry to 0;
  - `result_valid` to 0.
- After reset the block is ready for a new run; no partial results survive.
- Read cycle (read=1):
  - `row_reg` <= `row_data` at the clock edge.
  - `row_addr` = `cnt` is stable throughout, so `row_data` is that row's scores.
- Write cycle (write=1), all at the clock edge:
  - `max_addi_answer[cnt]` <= argmax(`row_reg`).
  - If `cnt` < NUM_OF_NODES-1, `cnt` <= `cnt`+1.
  - Otherwise `cnt` holds (saturates). The controller samples `cnt`==NUM_OF_NODES-1 during the last WRITE to enter DONE, so `cnt` must not wrap.
- Argmax rules:
  - Signed compare over k=0..WEIGHT_COLS-1, evaluated combinationally from `row_reg`.
  - Strict greater-than, so on a tie the lowest index wins.
  - The index is zero-extended to MAX_ADDRESS_WIDTH.
- Latency: row N's result is visible in `max_addi_answer[N]` one cycle after its write strobe. A full run takes 2*NUM_OF_NODES cycles after the controller leaves START.
- result_valid <= 1 on the first clock edge with `done`=1 and remains 1 until reset. When asserted, all entries are final.
- Strobe boundary conditions:
  - read and write are never both 1. If they are, write takes priority and read is ignored; this is an assertion failure in the bench.
  - A write without a preceding read commits the argmax of the stale `row_reg` (defined, not an error).
  - Strobes arriving after `result_valid`=1 are ignored: no register changes.
- No internal FSM beyond the `cnt` saturation/valid logic; sequencing belongs to the controller.

Decomposition:
- Shared readout package (`readout_pkg`):
  - the `state_t` enum (START, READ, WRITE, DONE), so the bench can monitor controller state;
  - localparams for the default NUM_OF_NODES, WEIGHT_COLS, DOT_PROD_WIDTH;
  - a function `last_node()` returning NUM_OF_NODES-1.
- Sub-module `argmax_compare`, purely combinational:
  - inputs: current best value/index and a candidate value/index;
  - outputs: the new best (signed, strict >).
  - Instantiated WEIGHT_COLS-1 times in a chain inside argmax_datapath.

Test Plan:
- Basic run, defaults. Rows:
  - node0 {5,9,2}; node1 {7,1,3}; node2 {0,0,8};
  - node3 {4,4,1}; node4 {-3,-1,-2}; node5 {10,20,30}.
  - Driven by the controller -> `max_addi_answer` = {1,0,2,0,1,2}; `result_valid`=1; `cnt`=5 held.
- Signed extremes: row {16'h8000, 16'h7FFF, 16'h0000} -> index 1; row {-1,-1,-1} -> index 0 (tie, lowest wins).
- Counter saturation: after the 6th write, issue 3 extra write strobes with `done`=1 -> `cnt` stays 5; results unchanged.
- Reset mid-operation: assert reset after node 2's write -> `cnt`=0, all entries 0, `result_valid`=0 immediately (asynchronous). A full rerun then yields the correct answers.
- Stale write: write strobe with no prior read after reset (`row_reg`=0) -> `max_addi_answer[0]`=0, `cnt`=1.
- Collision: read=write=1 in one cycle -> `row_reg` unchanged, write committed, bench assertion flags the violation.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared readout types and defaults for the argmax controller/datapath pair.
// Holds the controller state encoding so benches can monitor it.
package readout_pkg;

  typedef enum logic [1:0] {
    START,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam int DEF_NUM_OF_NODES   = 6;
  localparam int DEF_WEIGHT_COLS    = 3;
  localparam int DEF_DOT_PROD_WIDTH = 16;

  function automatic int last_node(
    input int num_nodes = DEF_NUM_OF_NODES
  );
    return num_nodes - 1;
  endfunction

endpackage

// File: rtl/argmax_datapath_if.sv
// Controller/buffer-facing bundle of the argmax datapath.
// master drives strobes and row scores; slave is the datapath.
interface argmax_datapath_if #(
  parameter int WEIGHT_COLS           = 3,
  parameter int DOT_PROD_WIDTH        = 16,
  parameter int NUM_OF_NODES          = 6,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(NUM_OF_NODES),
  parameter int MAX_ADDRESS_WIDTH     = $clog2(WEIGHT_COLS)
);

  logic read;
  logic write;
  logic done;
  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] row_data;
  logic [COUNTER_FEATURE_WIDTH-1:0] row_addr;
  logic [COUNTER_FEATURE_WIDTH-1:0] cnt;
  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [NUM_OF_NODES];
  logic result_valid;

  modport master (
    output read,
    output write,
    output done,
    output row_data,
    input  row_addr,
    input  cnt,
    input  max_addi_answer,
    input  result_valid
  );

  modport slave (
    input  read,
    input  write,
    input  done,
    input  row_data,
    output row_addr,
    output cnt,
    output max_addi_answer,
    output result_valid
  );

endinterface

// File: rtl/argmax_compare.sv
// One link of the argmax chain: keeps the best (value, index) pair.
// Strict signed greater-than, so earlier (lower) indices win ties.
module argmax_compare #(
  parameter int W  = 16,
  parameter int IW = 2
) (
  input  logic [W-1:0]  best_val,
  input  logic [IW-1:0] best_idx,
  input  logic [W-1:0]  cand_val,
  input  logic [IW-1:0] cand_idx,
  output logic [W-1:0]  new_val,
  output logic [IW-1:0] new_idx
);

  logic take;

  assign take    = $signed(cand_val) > $signed(best_val);
  assign new_val = take ? cand_val : best_val;
  assign new_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/argmax_datapath.sv
// Latches one node row of class scores and stores its argmax per node.
// Owns the saturating node counter consumed by the readout controller.
module argmax_datapath
  import readout_pkg::*;
#(
  parameter int WEIGHT_COLS           = DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH        = DEF_DOT_PROD_WIDTH,
  parameter int NUM_OF_NODES          = DEF_NUM_OF_NODES,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(NUM_OF_NODES),
  parameter int MAX_ADDRESS_WIDTH     = $clog2(WEIGHT_COLS)
) (
  input logic clk,
  input logic reset,
  argmax_datapath_if.slave bus
);

  localparam int DW = DOT_PROD_WIDTH;
  localparam int CW = COUNTER_FEATURE_WIDTH;
  localparam int AW = MAX_ADDRESS_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(last_node(NUM_OF_NODES));

  logic [CW-1:0] cnt;
  logic [WEIGHT_COLS*DW-1:0] row_reg;
  logic [AW-1:0] ans [NUM_OF_NODES];
  logic result_valid;
  logic [AW-1:0] best_idx;

  for (genvar k = 0; k < WEIGHT_COLS; k++) begin : g_chain
    logic [DW-1:0] val;
    logic [AW-1:0] idx;
    if (k == 0) begin : g_seed
      assign val = row_reg[0 +: DW];
      assign idx = '0;
    end else begin : g_link
      argmax_compare #(
        .W  (DW),
        .IW (AW)
      ) u_cmp (
        .best_val (g_chain[k-1].val),
        .best_idx (g_chain[k-1].idx),
        .cand_val (row_reg[k*DW +: DW]),
        .cand_idx (AW'(k)),
        .new_val  (val),
        .new_idx  (idx)
      );
    end
  end

  assign best_idx = g_chain[WEIGHT_COLS-1].idx;

  // Once results are valid the block freezes until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      row_reg      <= '0;
      result_valid <= 1'b0;
      for (int i = 0; i < NUM_OF_NODES; i++) begin
        ans[i] <= '0;
      end
    end else if (!result_valid) begin
      if (bus.write) begin
        ans[cnt] <= best_idx;
        if (cnt < LAST) begin
          cnt <= cnt + 1'b1;
        end
      end else if (bus.read) begin
        row_reg <= bus.row_data;
      end
      if (bus.done) begin
        result_valid <= 1'b1;
      end
    end
  end

  assign bus.cnt             = cnt;
  assign bus.row_addr        = cnt;
  assign bus.max_addi_answer = ans;
  assign bus.result_valid    = result_valid;

endmodule
